// File: rtl/div_sequencer_pkg.sv
// Shared constants and types for the iterative divider.
// The optional early-out path is enabled with the DIV_EARLY_OUT_EN macro.
package div_sequencer_pkg;
  localparam int DIV_ITER_64 = 64;
  localparam int DIV_ITER_32 = 32;

  typedef struct packed {
    logic w;      // W-form: 32-bit iteration count, result sign-extended
    logic rem;    // return remainder instead of quotient
    logic neg_q;  // quotient must be negated at the end
    logic neg_r;  // remainder must be negated at the end
  } div_ctrl_t;
endpackage

// File: rtl/div_sequencer_if.sv
// Request/response bundle between the execute stage (master) and the divider (slave).
interface div_sequencer_if #(parameter int XLEN = 64);
  logic            req_valid_i;
  logic            req_ready_o;
  logic [XLEN-1:0] operand_a_i;
  logic [XLEN-1:0] operand_b_i;
  logic            is_32_i;
  logic            is_unsigned_i;
  logic            rem_i;
  logic            kill_i;
  logic            resp_valid_o;
  logic            resp_ready_i;
  logic [XLEN-1:0] resp_value_o;

  modport master (
    output req_valid_i, operand_a_i, operand_b_i, is_32_i, is_unsigned_i, rem_i,
           kill_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_value_o
  );

  modport slave (
    input  req_valid_i, operand_a_i, operand_b_i, is_32_i, is_unsigned_i, rem_i,
           kill_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_value_o
  );
endinterface

// File: rtl/div_sequencer_div_step.sv
// One combinational restoring-division step on the {remainder, quotient} pair.
module div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);
  logic [XLEN:0] shl, diff;

  // One extra bit: a shifted remainder can exceed XLEN bits when the divisor is >= 2^(XLEN-1).
  always_comb begin
    shl   = {rem_i, quo_i[XLEN-1]};
    diff  = shl - {1'b0, dvs_i};
    quo_o = {quo_i[XLEN-2:0], ~diff[XLEN]};
    rem_o = diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0];
  end
endmodule

// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divider with request/response FSM (IDLE/BUSY/DONE).
// Optional DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  div_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  localparam int CW = $clog2(DIV_ITER_64);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, res_q, res_d;
  div_ctrl_t       ctrl_q, ctrl_d;

  logic            w, sa, sb, div0, ovf, early, accept;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_eff;
  logic [XLEN-1:0] step_rem, step_quo, fq, fr;

  function automatic logic [XLEN-1:0] fin(input logic wf, input logic [XLEN-1:0] x);
    return wf ? XLEN'($signed(x[31:0])) : x;
  endfunction

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Operand conditioning into the effective width, then magnitudes.
  always_comb begin
    w       = bus.is_32_i & (XLEN == 64);
    a_ext   = bus.operand_a_i;
    b_ext   = bus.operand_b_i;
    if (w) begin
      a_ext = bus.is_unsigned_i ? XLEN'(bus.operand_a_i[31:0]) : XLEN'($signed(bus.operand_a_i[31:0]));
      b_ext = bus.is_unsigned_i ? XLEN'(bus.operand_b_i[31:0]) : XLEN'($signed(bus.operand_b_i[31:0]));
    end
    sa      = ~bus.is_unsigned_i & a_ext[XLEN-1];
    sb      = ~bus.is_unsigned_i & b_ext[XLEN-1];
    mag_a   = sa ? -a_ext : a_ext;
    mag_b   = sb ? -b_ext : b_ext;
    min_eff = w ? XLEN'($signed(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
    div0    = (b_ext == '0);
    ovf     = ~bus.is_unsigned_i & (a_ext == min_eff) & (b_ext == '1);
`ifdef DIV_EARLY_OUT_EN
    early   = (mag_a < mag_b) & ~div0;
`else
    early   = 1'b0;
`endif
    accept  = bus.req_valid_i & (state_q == IDLE) & ~bus.kill_i;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    ctrl_d  = ctrl_q;
    fq      = ctrl_q.neg_q ? -step_quo : step_quo;
    fr      = ctrl_q.neg_r ? -step_rem : step_rem;
    unique case (state_q)
      IDLE: if (accept) begin
        ctrl_d = '{w: w, rem: bus.rem_i, neg_q: sa ^ sb, neg_r: sa};
        dvs_d  = mag_b;
        rem_d  = '0;
        // W-form dividend is left-aligned so 32 steps consume exactly its bits.
        quo_d  = w ? (mag_a << (XLEN - 32)) : mag_a;
        cnt_d  = w ? CW'(DIV_ITER_32 - 1) : CW'(XLEN - 1);
        if (div0) begin
          res_d   = bus.rem_i ? fin(w, a_ext) : '1;
          state_d = DONE;
        end else if (ovf) begin
          res_d   = bus.rem_i ? '0 : fin(w, a_ext);
          state_d = DONE;
        end else if (early) begin
          res_d   = bus.rem_i ? fin(w, a_ext) : '0;
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          res_d   = fin(ctrl_q.w, ctrl_q.rem ? fr : fq);
          state_d = DONE;
        end
      end
      DONE: if (bus.resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.kill_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.req_ready_o  = (state_q == IDLE);
  assign bus.resp_valid_o = (state_q == DONE);
  assign bus.resp_value_o = res_q;
endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Iterative radix-2 restoring divider with its controlling FSM.
- Executes DIV-type ops (DIV/DIVU/REM/REMU and their W forms) dispatched from the execute stage when `op_type == DIV`.
- The issuing stage drives operand and control inputs from decoded `div.is_unsigned`, `div.rem` and `is_32`.
- Single outstanding operation; valid/ready on both request and response sides; flushable.

Parameters:
- XLEN, 64, datapath width; 32 or 64 supported. When 32, `is_32_i` is ignored and treated as 0.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when both valid and ready are high
- operand_a_i  in  XLEN  dividend (rs1)
- operand_b_i  in  XLEN  divisor (rs2)
- is_32_i  in  1  W-form op
- is_unsigned_i  in  1  unsigned op
- rem_i  in  1  return remainder instead of quotient
- kill_i  in  1  flush; abandons any operation
- resp_valid_o  out  1  result valid
- resp_ready_i  in  1  consumer accepts result
- resp_value_o  out  XLEN  result

Behaviour:
- Interface: one clock `clk_i`; reset `rst_ni` is asynchronous and active-low.
- Reset values:
  - state = IDLE
  - req_ready_o = 1
  - resp_valid_o = 0
  - resp_value_o = 0
  - all internal registers = 0
- `req_ready_o` = (state == IDLE). It has no combinational path from `resp_ready_i`.
- States:
  - IDLE: on accept, latch control. Compute operand magnitudes:
    - W form: take the low 32 bits, sign-extended (signed) or zero-extended (unsigned).
    - Signed ops: take absolute values. Record `neg_q = sign_a ^ sign_b` and `neg_r = sign_a`.
    - Special cases go to DONE; otherwise go to BUSY with counter N−1, where N = 32 if W form, else XLEN.
  - BUSY: one restoring step per cycle.
    - Shift the {remainder, quotient} pair left by 1.
    - Trial-subtract the divisor magnitude. On non-negative, keep the difference and set quotient bit 0.
    - When counter == 0, apply sign fixup (negate quotient if `neg_q`, negate remainder if `neg_r`), select quotient or remainder, and register it into `resp_value_o`. Go to DONE.
  - DONE: `resp_valid_o` = 1. `resp_value_o` is held stable until `resp_ready_i`, then go to IDLE.
- Latency, counted from the accept edge:
  - normal op: `resp_valid_o` high N+1 cycles later (65 for 64-bit, 33 for W).
  - special case: `resp_valid_o` high 1 cycle later.
- Special cases, resolved in IDLE:
  - divisor == 0: quotient = all ones; remainder = dividend.
  - signed overflow (dividend = most-negative value, divisor = −1, in the effective width): quotient = dividend; remainder = 0.
- W form: the final 32-bit result is sign-extended from bit 31 to XLEN. This applies to DIVUW/REMUW too.
- kill_i:
  - In any state, kill forces the next state to IDLE and `resp_valid_o` to 0 next cycle.
  - If asserted in the same cycle as an accept, kill wins and the request is dropped.
  - A response in DONE that is killed is never delivered, even if `resp_ready_i` is high in that cycle.
- Reset mid-operation: immediate return to reset values; no result is emitted.
- A response handshake in DONE and a new request cannot coincide; `req_ready_o` is 0 in DONE.

Optional Feature:
- Macro `DIV_EARLY_OUT_EN`.
- Defined: in IDLE, if unsigned |dividend| < |divisor| in the effective width (and the divisor is non-zero), go straight to DONE. Result: quotient 0, remainder = original dividend (W-form sign-extended). Latency 1 cycle.
- Undefined: such operands take the full N+1 cycle path. Results are identical either way.

Decomposition:
- Add to `cpu_common`: constant `DIV_ITER_64 = 64`, `DIV_ITER_32 = 32`.
- Reuse the existing `decoded_instr_t.div` field semantics. The FSM state enum (IDLE, BUSY, DONE) stays local to the module.
- One natural sub-module: `div_step`, a purely combinational single restoring step. Inputs: remainder, quotient, divisor. Outputs: next remainder, next quotient.

Test Plan:
- DIV, a = −7 (0xFFFF_FFFF_FFFF_FFF9), b = 2 → result 0xFFFF_FFFF_FFFF_FFFD; resp_valid 65 cycles after accept. REM on the same operands → 0xFFFF_FFFF_FFFF_FFFF.
- REMUW, a = 0x1234_5678_0000_0064, b = 7 → result 2; latency 33. DIVUW, a = 0xFFFF_FFFE, b = 1 → 0xFFFF_FFFF_FFFF_FFFE (sign-extended).
- DIVW, a = 0x8000_0000, b = 0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000; REMW on the same operands → 0. Latency 1 in both cases.
- DIV, a = 5, b = 0 → 0xFFFF_FFFF_FFFF_FFFF; REM, a = 5, b = 0 → 5; latency 1.
- Kill on BUSY cycle 10 → no resp_valid ever; req_ready high the next cycle. A following DIVU 100/7 returns 14.
- Hold resp_ready low for 5 cycles in DONE → resp_value stable, req_ready low; a req_valid pulse during that time is not accepted. With `DIV_EARLY_OUT_EN`, DIVU 3/10 → 0 in 1 cycle.
